// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done bus for seq_chunk_adder.
// Optional ovf member exists only when SEQ_CHUNK_ADDER_OVF_EN is defined.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 9
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             Cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, sub, A, B, Cin,
        input  busy, done, S, Cout, ovf
    );

    modport slave (
        input  start, sub, A, B, Cin,
        output busy, done, S, Cout, ovf
    );
`else
    modport master (
        output start, sub, A, B, Cin,
        input  busy, done, S, Cout
    );

    modport slave (
        input  start, sub, A, B, Cin,
        output busy, done, S, Cout
    );
`endif
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock with a registered carry.
// Define SEQ_CHUNK_ADDER_OVF_EN to add the signed overflow output ovf.
module seq_chunk_adder #(
    parameter int WIDTH = 9,
    parameter int CHUNK = 3
) (
    input logic               clk,
    input logic               rst,
    seq_chunk_adder_if.slave  bus
);
    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad
        $error("seq_chunk_adder: illegal WIDTH/CHUNK");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] s_q;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             busy_q;
    logic             done_q;
    logic             cout_q;
    logic [31:0]      base;
    logic [CHUNK-1:0] a_c;
    logic [CHUNK-1:0] b_c;
    logic [CHUNK:0]   csum;
    logic             last;

    // One chunk of the ripple sum and the result with that chunk merged in
    always_comb begin
        base   = 32'(idx) * 32'(CHUNK);
        a_c    = opa[base +: CHUNK];
        b_c    = opb[base +: CHUNK];
        csum   = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
        res_nx = res;
        res_nx[base +: CHUNK] = csum[CHUNK-1:0];
        last   = (idx == IW'(NCHUNK - 1));
    end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_nx;

    // Carry into the MSB is recovered from the MSB sum bit and its inputs
    always_comb begin
        ovf_nx = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ csum[CHUNK-1] ^ csum[CHUNK];
    end

    // Overflow flag is written together with S
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= ovf_nx;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    // Control FSM and datapath registers; S/Cout change only on done
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            s_q    <= '0;
            cout_q <= 1'b0;
            idx    <= '0;
            carry  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            res    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        opa    <= bus.A;
                        opb    <= bus.sub ? ~bus.B : bus.B;
                        carry  <= bus.sub ? ~bus.Cin : bus.Cin;
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_nx;
                    carry <= csum[CHUNK];
                    idx   <= idx + 1'b1;
                    if (last) begin
                        s_q    <= res_nx;
                        cout_q <= csum[CHUNK];
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed and swept checks of seq_chunk_adder at 9/3, 8/2 and 4/4.
module tb_seq_chunk_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(9)) if9 ();
    seq_chunk_adder_if #(.WIDTH(8)) if8 ();
    seq_chunk_adder_if #(.WIDTH(4)) if4 ();

    seq_chunk_adder #(.WIDTH(9), .CHUNK(3)) u9 (.clk(clk), .rst(rst), .bus(if9.slave));
    seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));
    seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

    typedef struct {
        logic       sub;
        logic [8:0] a;
        logic [8:0] b;
        logic       cin;
        logic [8:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vt [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input int w, input logic sb,
                                          input int a, input int b, input logic c);
        int s;
        int co;
        if (!sb) return 32'(a + b + int'(c));
        s  = (a - b - int'(c)) & ((1 << w) - 1);
        co = (a >= b + int'(c)) ? 1 : 0;
        return 32'((co << w) | s);
    endfunction

    task automatic run9(input logic sb, input logic [8:0] a, input logic [8:0] b,
                        input logic c, output logic [8:0] s, output logic co,
                        output logic ov, output int lat, output int bz);
        if9.sub = sb; if9.A = a; if9.B = b; if9.Cin = c; if9.start = 1'b1;
        @(negedge clk);
        if9.start = 1'b0;
        lat = 0;
        bz  = 0;
        while (!if9.done && lat < 20) begin
            if (if9.busy) bz++;
            @(negedge clk);
            lat++;
        end
        s  = if9.S;
        co = if9.Cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ov = if9.ovf;
`else
        ov = 1'b0;
`endif
    endtask

    task automatic run8(input logic sb, input int a, input int b, input logic c,
                        output logic [31:0] r);
        int lat;
        if8.sub = sb; if8.A = 8'(a); if8.B = 8'(b); if8.Cin = c; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        lat = 0;
        while (!if8.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = (lat < 20) ? 32'({if8.Cout, if8.S}) : 32'hDEAD_BEEF;
    endtask

    task automatic run4(input logic sb, input int a, input int b, input logic c,
                        output logic [31:0] r);
        int lat;
        if4.sub = sb; if4.A = 4'(a); if4.B = 4'(b); if4.Cin = c; if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        lat = 0;
        while (!if4.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = (lat < 20) ? 32'({if4.Cout, if4.S}) : 32'hDEAD_BEEF;
    endtask

    initial begin
        logic [8:0]  s;
        logic        co;
        logic        ov;
        logic [31:0] r;
        int          lat;
        int          bz;
        int          dn;
        int          held;

        vt[0] = '{1'b0, 9'h1FF, 9'h001, 1'b0, 9'h000, 1'b1, 1'b0};
        vt[1] = '{1'b1, 9'h005, 9'h007, 1'b0, 9'h1FE, 1'b0, 1'b0};
        vt[2] = '{1'b1, 9'h007, 9'h005, 1'b1, 9'h001, 1'b1, 1'b0};
        vt[3] = '{1'b0, 9'h003, 9'h004, 1'b0, 9'h007, 1'b0, 1'b0};
        vt[4] = '{1'b0, 9'h00A, 9'h014, 1'b1, 9'h01F, 1'b0, 1'b0};
        vt[5] = '{1'b0, 9'h0FF, 9'h001, 1'b0, 9'h100, 1'b0, 1'b1};
        vt[6] = '{1'b0, 9'h1FF, 9'h1FF, 1'b1, 9'h1FF, 1'b1, 1'b0};
        vt[7] = '{1'b1, 9'h000, 9'h000, 1'b1, 9'h1FF, 1'b0, 1'b0};
        vt[8] = '{1'b1, 9'h100, 9'h0FF, 1'b0, 9'h001, 1'b1, 1'b1};
        vt[9] = '{1'b1, 9'h000, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0};

        {if9.start, if9.sub, if9.A, if9.B, if9.Cin} = '0;
        {if8.start, if8.sub, if8.A, if8.B, if8.Cin} = '0;
        {if4.start, if4.sub, if4.A, if4.B, if4.Cin} = '0;

        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(if9.busy), 0);
        chk("rst_done", 32'(if9.done), 0);
        chk("rst_S",    32'(if9.S), 0);
        chk("rst_Cout", 32'(if9.Cout), 0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        chk("rst_ovf",  32'(if9.ovf), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run9(vt[i].sub, vt[i].a, vt[i].b, vt[i].cin, s, co, ov, lat, bz);
            chk($sformatf("v%0d_S", i),    32'(s),   32'(vt[i].s));
            chk($sformatf("v%0d_Cout", i), 32'(co),  32'(vt[i].co));
            chk($sformatf("v%0d_lat", i),  32'(lat), 3);
            chk($sformatf("v%0d_busy", i), 32'(bz),  3);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            chk($sformatf("v%0d_ovf", i),  32'(ov),  32'(vt[i].ov));
`endif
            @(negedge clk);
        end

        if9.sub = 1'b0; if9.A = 9'd3; if9.B = 9'd4; if9.Cin = 1'b0; if9.start = 1'b1;
        @(negedge clk);
        bz = int'(if9.busy);
        dn = 0;
        s  = '0;
        if9.A = 9'h100;
        @(negedge clk);
        if9.start = 1'b0;
        if9.A = 9'h000;
        bz += int'(if9.busy);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bz += int'(if9.busy);
            if (if9.done) begin
                dn++;
                s = if9.S;
            end
        end
        chk("busy_start_done_cnt", 32'(dn), 1);
        chk("busy_start_S",        32'(s),  7);
        chk("busy_start_busycyc",  32'(bz), 3);

        run9(1'b0, 9'd3, 9'd4, 1'b0, s, co, ov, lat, bz);
        chk("b2b_first_S", 32'(s), 7);
        if9.A = 9'd10; if9.B = 9'd20; if9.Cin = 1'b1; if9.start = 1'b1;
        @(negedge clk);
        if9.start = 1'b0;
        lat  = 1;
        held = 1;
        while (!if9.done && lat < 20) begin
            if (if9.S !== 9'd7) held = 0;
            @(negedge clk);
            lat++;
        end
        chk("b2b_S_held",  32'(held),   1);
        chk("b2b_spacing", 32'(lat),    4);
        chk("b2b_S",       32'(if9.S),  31);
        chk("b2b_Cout",    32'(if9.Cout), 0);
        @(negedge clk);

        if9.A = 9'h1FF; if9.B = 9'h1FF; if9.Cin = 1'b1; if9.start = 1'b1;
        @(negedge clk);
        if9.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 32'(if9.busy), 0);
        chk("mid_rst_done", 32'(if9.done), 0);
        chk("mid_rst_S",    32'(if9.S),    0);
        chk("mid_rst_Cout", 32'(if9.Cout), 0);
        dn = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dn += int'(if9.done);
        end
        chk("mid_rst_no_done", 32'(dn), 0);
        run9(1'b0, 9'd2, 9'd3, 1'b0, s, co, ov, lat, bz);
        chk("after_rst_S",   32'(s),   5);
        chk("after_rst_lat", 32'(lat), 3);
        @(negedge clk);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int m = 0; m < 4; m++) begin
                    run4(m[1], a, b, m[0], r);
                    chk($sformatf("w4 sub=%0d a=%0d b=%0d c=%0d", m[1], a, b, m[0]),
                        r, model(4, m[1], a, b, m[0]));
                end
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int m = 0; m < 4; m++) begin
                    run8(m[1], i * 17, (j * 17 + 5) & 255, m[0], r);
                    chk($sformatf("w8 sub=%0d a=%0d b=%0d c=%0d", m[1], i * 17,
                                  (j * 17 + 5) & 255, m[0]),
                        r, model(8, m[1], i * 17, (j * 17 + 5) & 255, m[0]));
                end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
